// File: rtl/imul_generate2.sv
// Unsigned WIDTH x WIDTH -> 2*WIDTH array multiplier built from generated AND rows and
// ripple-carry full-adder rows, with a single registered output stage.
module imul_generate2 #(
    parameter int WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   oResult
);

    // pp[i][j] = A[j] & B[i]
    logic [WIDTH-1:0][WIDTH-1:0] pp;
    // acc[i] is the WIDTH-bit running sum leaving row i; bit 0 is final product bit i
    logic [WIDTH-1:0][WIDTH-1:0] acc;
    // rc[i] is the carry-out of row i, fed into the MSB of row i+1
    logic [WIDTH-1:0]            rc;
    logic [2*WIDTH-1:0]          prod;

    genvar i, j;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_pp_row
            for (j = 0; j < WIDTH; j++) begin : g_pp_bit
                assign pp[i][j] = A[j] & B[i];
            end
        end

        assign acc[0] = pp[0];
        assign rc[0]  = 1'b0;

        for (i = 1; i < WIDTH; i++) begin : g_add_row
            logic [WIDTH-1:0] addend;
            logic [WIDTH:0]   c;

            // Previous sum shifted down one place, with the previous row's carry on top
            assign addend = {rc[i-1], acc[i-1][WIDTH-1:1]};
            assign c[0]   = 1'b0;

            for (j = 0; j < WIDTH; j++) begin : g_fa
                assign acc[i][j] = addend[j] ^ pp[i][j] ^ c[j];
                assign c[j+1]    = (addend[j] & pp[i][j]) | (c[j] & (addend[j] ^ pp[i][j]));
            end

            assign rc[i] = c[WIDTH];
        end

        for (i = 0; i < WIDTH - 1; i++) begin : g_low_bits
            assign prod[i] = acc[i][0];
        end
    endgenerate

    // Top WIDTH+1 bits come straight out of the last row
    assign prod[2*WIDTH-1:WIDTH-1] = {rc[WIDTH-1], acc[WIDTH-1]};

    // NOTE: non-blocking assignment keeps the register update race-free against other clocked logic.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            oResult <= '0;
        end else begin
            oResult <= prod;
        end
    end

endmodule

// File: tb/tb_imul_generate2.sv
// Scoreboard bench for imul_generate2: expected products are queued when operands are
// driven and compared one cycle later, away from the rising edge.
module tb_imul_generate2;

    localparam int W = 16;

    logic             clock;
    logic             reset;
    logic [W-1:0]     A;
    logic [W-1:0]     B;
    logic [2*W-1:0]   oResult;

    logic [2*W-1:0]   sb_q[$];
    logic [2*W-1:0]   exp_v;
    int               vectors;
    int               miscompares;

    imul_generate2 #(.WIDTH(W)) dut (
        .clock   (clock),
        .reset   (reset),
        .A       (A),
        .B       (B),
        .oResult (oResult)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] wa;
        logic [2*W-1:0] wb;
        wa = {{W{1'b0}}, a};
        wb = {{W{1'b0}}, b};
        return wa * wb;
    endfunction

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b);
        A = a;
        B = b;
        sb_q.push_back(model(a, b));
    endtask

    task automatic test_reset();
        reset = 1'b1;
        A = 16'd4;
        B = 16'd5;
        #3;
        vectors++;
        if (oResult !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_initial: got %h expected %h", oResult, 32'd0);
        end
        @(posedge clock); #1;
        vectors++;
        if (oResult !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_held_edge: got %h expected %h", oResult, 32'd0);
        end
        reset = 1'b0;
        drive(16'd4, 16'd5);
        @(posedge clock); #1;
        exp_v = sb_q.pop_front();
        vectors++;
        if (oResult !== exp_v || exp_v !== 32'h0000_0014) begin
            miscompares++;
            $display("FAIL reset_release: got %h expected %h", oResult, exp_v);
        end
    endtask

    task automatic test_max();
        drive(16'hFFFF, 16'hFFFF);
        @(posedge clock); #1;
        exp_v = sb_q.pop_front();
        vectors++;
        if (oResult !== 32'hFFFE_0001) begin
            miscompares++;
            $display("FAIL max_operands: got %h expected %h", oResult, 32'hFFFE_0001);
        end
    endtask

    task automatic test_pipeline();
        logic [W-1:0] av[2];
        logic [W-1:0] bv[2];
        av[0] = 16'h0000; bv[0] = 16'h1234;
        av[1] = 16'hABCD; bv[1] = 16'h0001;
        for (int k = 0; k < 2; k++) begin
            drive(av[k], bv[k]);
            @(posedge clock); #1;
            exp_v = sb_q.pop_front();
            vectors++;
            if (oResult !== exp_v) begin
                miscompares++;
                $display("FAIL pipeline_%0d: got %h expected %h", k, oResult, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0]   av[3];
        logic [W-1:0]   bv[3];
        logic [2*W-1:0] ref_v[3];
        av[0] = 16'd3;     bv[0] = 16'd7;   ref_v[0] = 32'd21;
        av[1] = 16'd256;   bv[1] = 16'd256; ref_v[1] = 32'd65536;
        av[2] = 16'h8000;  bv[2] = 16'd2;   ref_v[2] = 32'h0001_0000;
        for (int k = 0; k < 3; k++) begin
            drive(av[k], bv[k]);
            @(posedge clock); #1;
            exp_v = sb_q.pop_front();
            vectors++;
            if (oResult !== ref_v[k] || oResult !== exp_v) begin
                miscompares++;
                $display("FAIL back_to_back_%0d: got %h expected %h", k, oResult, ref_v[k]);
            end
        end
    endtask

    task automatic test_async_reset();
        drive(16'd4, 16'd5);
        @(posedge clock); #1;
        exp_v = sb_q.pop_front();
        vectors++;
        if (oResult !== 32'd20) begin
            miscompares++;
            $display("FAIL async_pre: got %h expected %h", oResult, 32'd20);
        end
        // Mid-cycle: reset must clear the output before the next rising edge
        drive(16'd9, 16'd9);
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if (oResult !== 32'd0) begin
            miscompares++;
            $display("FAIL async_immediate: got %h expected %h", oResult, 32'd0);
        end
        sb_q.delete();
        for (int k = 0; k < 2; k++) begin
            @(posedge clock); #1;
            vectors++;
            if (oResult !== 32'd0) begin
                miscompares++;
                $display("FAIL async_hold_%0d: got %h expected %h", k, oResult, 32'd0);
            end
        end
        reset = 1'b0;
        drive(16'd12, 16'd11);
        @(posedge clock); #1;
        exp_v = sb_q.pop_front();
        vectors++;
        if (oResult !== exp_v) begin
            miscompares++;
            $display("FAIL async_release: got %h expected %h", oResult, exp_v);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 1000; k++) begin
            drive(W'($urandom), W'($urandom));
            @(posedge clock); #1;
            exp_v = sb_q.pop_front();
            vectors++;
            if (oResult !== exp_v) begin
                miscompares++;
                $display("FAIL random_%0d: got %h expected %h", k, oResult, exp_v);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_max();
        test_pipeline();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
